// File: rtl/request_encoder.sv
// request_encoder
//   Collects request lines into a pending register and hands out one pending
//   request at a time as a binary address, using a valid/ack handshake. A
//   serviced bit is cleared only when its grant is acked. If a request and the
//   ack for the same bit land on the same edge, the request wins and the bit
//   stays pending.
//
// Build option:
//   ROUND_ROBIN_EN - when defined, the scan for the next grant starts at a
//                    rotating pointer instead of always at index 0.
//
// Parameters:
//   N_REQ    number of request lines (must equal 2**ADDR_W)
//   ADDR_W   width of the encoded address
//
// Ports:
//   clk       rising-edge clock
//   rst_n     asynchronous active-low reset
//   req       request lines; a high bit sets the matching pending bit
//   enable    allows a new grant to start (an active grant always completes)
//   ack       consumer accepts addr_out; ignored while valid is low
//   clr_ovf   synchronous clear of ovf (a new overflow on the same edge wins)
//   addr_out  address of the granted request; stale while valid is low
//   valid     addr_out holds a live grant
//   pending   current pending register
//   ovf       sticky flag: a request hit a bit that was already pending
module request_encoder #(
    parameter int unsigned N_REQ  = 4,
    parameter int unsigned ADDR_W = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [N_REQ-1:0]  req,
    input  logic              enable,
    input  logic              ack,
    input  logic              clr_ovf,
    output logic [ADDR_W-1:0] addr_out,
    output logic              valid,
    output logic [N_REQ-1:0]  pending,
    output logic              ovf
);

    typedef enum logic [0:0] {StIdle, StGrant} state_e;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [N_REQ-1:0]  pending_q, pending_d;
    logic              ovf_q, ovf_d;

    logic [N_REQ-1:0]  clr_mask;
    logic              ack_fire;
    logic              sel_found;
    logic [ADDR_W-1:0] sel_idx;

    assign ack_fire = valid & ack;

    // Bit to clear this edge: only the granted bit, and only when it is acked.
    always_comb begin
        clr_mask = '0;
        if (ack_fire) begin
            clr_mask[addr_q] = 1'b1;
        end
    end

    // A request is ORed in after the clear, so a request always beats an ack.
    always_comb begin
        pending_d = (pending_q & ~clr_mask) | req;
        ovf_d     = (|(req & pending_q & ~clr_mask)) | (ovf_q & ~clr_ovf);
    end

`ifdef ROUND_ROBIN_EN
    logic [ADDR_W-1:0] rr_ptr_q, rr_ptr_d;
    logic [ADDR_W-1:0] scan_idx;

    // The index wraps naturally because N_REQ == 2**ADDR_W.
    always_comb begin
        sel_found = 1'b0;
        sel_idx   = '0;
        scan_idx  = '0;
        for (int i = 0; i < int'(N_REQ); i++) begin
            scan_idx = rr_ptr_q + ADDR_W'(i);
            if (!sel_found && pending_q[scan_idx]) begin
                sel_found = 1'b1;
                sel_idx   = scan_idx;
            end
        end
    end

    assign rr_ptr_d = ack_fire ? addr_q + 1'b1 : rr_ptr_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr_q <= '0;
        end else begin
            rr_ptr_q <= rr_ptr_d;
        end
    end
`else
    // Fixed priority: scan downward so that the lowest set index is the one kept.
    always_comb begin
        sel_found = |pending_q;
        sel_idx   = '0;
        for (int i = int'(N_REQ) - 1; i >= 0; i--) begin
            if (pending_q[i]) begin
                sel_idx = ADDR_W'(i);
            end
        end
    end
`endif

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            addr_q    <= '0;
            pending_q <= '0;
            ovf_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            pending_q <= pending_d;
            ovf_q     <= ovf_d;
        end
    end

    // Next state. The grant decision uses the registered pending value, so there
    // is always at least one idle cycle between grants.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (enable && sel_found) state_d = StGrant;
            StGrant: if (ack)                 state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Outputs. The address is captured when a grant starts and held until the
    // next grant starts.
    always_comb begin
        addr_d = addr_q;
        if (state_q == StIdle && state_d == StGrant) begin
            addr_d = sel_idx;
        end
    end

    assign valid    = (state_q == StGrant);
    assign addr_out = addr_q;
    assign pending  = pending_q;
    assign ovf      = ovf_q;

endmodule

// File: tb/tb_request_encoder.sv
// Bench for request_encoder: directed vectors; expected grant addresses are
// queued by the stimulus and checked by an independent grant monitor.
module tb_request_encoder;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] req;
    logic       enable;
    logic       ack;
    logic       clr_ovf;
    logic [1:0] addr_out;
    logic       valid;
    logic [3:0] pending;
    logic       ovf;

    int n_tests = 0;
    int n_fail  = 0;

    logic [1:0] exp_q[$];
    logic       prev_valid = 1'b0;

    request_encoder #(
        .N_REQ  (4),
        .ADDR_W (2)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .req      (req),
        .enable   (enable),
        .ack      (ack),
        .clr_ovf  (clr_ovf),
        .addr_out (addr_out),
        .valid    (valid),
        .pending  (pending),
        .ovf      (ovf)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Grant monitor: on every rising valid, compare addr_out with the next queued address.
    always @(negedge clk) begin
        if (valid && !prev_valid) begin
            n_tests++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL grant_unexpected: got addr %0d expected no grant", addr_out);
            end else begin
                logic [1:0] e;
                e = exp_q.pop_front();
                if (addr_out !== e) begin
                    n_fail++;
                    $display("FAIL grant_addr: got %0d expected %0d", addr_out, e);
                end
            end
        end
        prev_valid = valid;
    end

`ifdef ROUND_ROBIN_EN
    localparam logic [1:0] T3First  = 2'd3;
    localparam logic [1:0] T3Second = 2'd1;
    localparam logic [3:0] T3Mid    = 4'b0010;
    localparam int         T6Grants = 5;
`else
    localparam logic [1:0] T3First  = 2'd1;
    localparam logic [1:0] T3Second = 2'd3;
    localparam logic [3:0] T3Mid    = 4'b1000;
    localparam int         T6Grants = 3;
`endif

    initial begin
        logic [1:0] t6_seq [5];
        t6_seq[0] = 2'd0;
`ifdef ROUND_ROBIN_EN
        t6_seq[1] = 2'd1; t6_seq[2] = 2'd2; t6_seq[3] = 2'd3; t6_seq[4] = 2'd0;
`else
        t6_seq[1] = 2'd0; t6_seq[2] = 2'd0; t6_seq[3] = 2'd0; t6_seq[4] = 2'd0;
`endif
        rst_n = 1'b0; req = '0; enable = 1'b0; ack = 1'b0; clr_ovf = 1'b0;
        repeat (2) tick();
        check("rst_valid", 32'(valid), 0);
        check("rst_pending", 32'(pending), 0);
        check("rst_ovf", 32'(ovf), 0);
        check("rst_addr", 32'(addr_out), 0);
        rst_n = 1'b1;

        // Single request
        exp_q.push_back(2'd2);
        req = 4'b0100; enable = 1'b1;
        tick();
        req = '0;
        check("t2_pending_set", 32'(pending), 32'b0100);
        check("t2_valid_lat1", 32'(valid), 0);
        tick();
        check("t2_valid", 32'(valid), 1);
        ack = 1'b1;
        tick();
        ack = 1'b0;
        check("t2_valid_off", 32'(valid), 0);
        check("t2_pending_clr", 32'(pending), 0);

        // Two requests, ack held high
        exp_q.push_back(T3First);
        exp_q.push_back(T3Second);
        req = 4'b1010; ack = 1'b1;
        tick();
        req = '0;
        check("t3_pending", 32'(pending), 32'b1010);
        tick();
        check("t3_grant1", 32'(valid), 1);
        tick();
        check("t3_gap", 32'(valid), 0);
        check("t3_pending_mid", 32'(pending), 32'(T3Mid));
        tick();
        check("t3_grant2", 32'(valid), 1);
        tick();
        check("t3_done", 32'(valid), 0);
        check("t3_pending_end", 32'(pending), 0);
        ack = 1'b0;

        // Enable gating
        enable = 1'b0; req = 4'b0001;
        tick();
        req = '0;
        tick();
        tick();
        check("t4_gated", 32'(valid), 0);
        check("t4_pending", 32'(pending), 32'b0001);
        exp_q.push_back(2'd0);
        enable = 1'b1;
        tick();
        check("t4_grant", 32'(valid), 1);
        enable = 1'b0;
        tick();
        tick();
        check("t4_held", 32'(valid), 1);
        check("t4_addr_held", 32'(addr_out), 0);
        ack = 1'b1;
        tick();
        check("t4_done", 32'(valid), 0);
        check("t4_pending_end", 32'(pending), 0);
        ack = 1'b0; enable = 1'b1;

        // Overflow and set-beats-clear
        exp_q.push_back(2'd2);
        req = 4'b0100;
        tick();
        req = '0;
        tick();
        check("t5_grant", 32'(valid), 1);
        req = 4'b0100;
        tick();
        check("t5_ovf_set", 32'(ovf), 1);
        req = '0; clr_ovf = 1'b1;
        tick();
        clr_ovf = 1'b0;
        check("t5_ovf_clr", 32'(ovf), 0);
        check("t5_still_valid", 32'(valid), 1);
        exp_q.push_back(2'd2);
        req = 4'b0100; ack = 1'b1;
        tick();
        req = '0;
        check("t5_ack_valid", 32'(valid), 0);
        check("t5_set_beats_clr", 32'(pending), 32'b0100);
        check("t5_no_ovf", 32'(ovf), 0);
        tick();
        check("t5_regrant", 32'(valid), 1);
        tick();
        check("t5_regrant_done", 32'(pending), 0);
        ack = 1'b0;

        // Overflow set and clear on the same edge: set wins
        enable = 1'b0; req = 4'b0001;
        tick();
        clr_ovf = 1'b1;
        tick();
        check("t5_set_wins", 32'(ovf), 1);
        req = '0;
        tick();
        check("t5_clr_again", 32'(ovf), 0);
        clr_ovf = 1'b0;
        exp_q.push_back(2'd0);
        enable = 1'b1; ack = 1'b1;
        tick();
        tick();
        check("t5_drain", 32'(pending), 0);
        ack = 1'b0;

        // Asynchronous reset in the middle of a grant
        enable = 1'b0; req = 4'b1000;
        tick();
        tick();
        check("t1_pre_ovf", 32'(ovf), 1);
        req = '0;
        exp_q.push_back(2'd3);
        enable = 1'b1;
        tick();
        check("t1_pre_valid", 32'(valid), 1);
        @(negedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("t1_async_valid", 32'(valid), 0);
        check("t1_async_pending", 32'(pending), 0);
        check("t1_async_ovf", 32'(ovf), 0);
        check("t1_async_addr", 32'(addr_out), 0);
        tick();
        rst_n = 1'b1;

        // All requests held, every grant acked
        for (int i = 0; i < T6Grants; i++) exp_q.push_back(t6_seq[i]);
        req = 4'b1111; enable = 1'b1; ack = 1'b1;
        repeat (1 + 2 * T6Grants) tick();
        enable = 1'b0; ack = 1'b0; req = '0;
        repeat (3) tick();
        check("grants_outstanding", 32'(exp_q.size()), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
